// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//
// APB completer that sits on one select line of the APB bridge. It holds a
// byte-wide register-file memory, inserts a fixed number of wait states in
// every access phase, and reports out-of-range addresses with PSLVERR.
//
// The bridge decodes PADDR[8] onto the select lines, so only the low address
// bits arrive here. Addresses at or above MEM_DEPTH have no storage behind
// them. Writes to them are dropped, and any access to them completes with an
// error.
//
// Parameters
//   ADDR_W      local address width
//   DATA_W      data width
//   MEM_DEPTH   number of implemented locations (must be <= 2**ADDR_W)
//   WAIT_CYCLES wait states inserted in each access phase (0 = zero-wait)
//
// Ports
//   PCLK     in   clock, rising edge
//   PRESET   in   asynchronous, active-high reset
//   PSEL     in   slave select from the bridge
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   local address            [ADDR_W-1:0]
//   PWDATA   in   write data               [DATA_W-1:0]
//   PRDATA   out  read data, 0 unless a good read is completing
//   PREADY   out  transfer completes on the edge where PREADY = 1
//   PSLVERR  out  error response, only ever asserted together with PREADY
// -----------------------------------------------------------------------------
module apb_slave_mem #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int MEM_DEPTH   = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  // The wait counter needs at least one bit, even when there are no wait
  // states.
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYCLES);
  // The limit is one bit wider than the address, so a depth of 2**ADDR_W
  // can still be represented.
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

  // ---------------------------------------------------------------------------
  // Decode of the latched transfer
  // ---------------------------------------------------------------------------
  logic              in_range;
  logic [IDX_W-1:0]  mem_idx;
  logic              ready;
  logic              complete;
  logic              mem_we;

  assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
  assign mem_idx  = addr_q[IDX_W-1:0];

  // Ready depends only on registered state. Bus inputs cannot ripple
  // through to PREADY.
  assign ready    = (state_q == ACCESS) && (cnt_q == '0);
  assign complete = ready && PSEL && PENABLE;
  assign mem_we   = complete && write_q && in_range;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path through
    // this block can leave a value unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;

    unique case (state_q)
      IDLE: begin
        // Only a proper setup phase starts a transfer. If PSEL and PENABLE
        // are both high without a preceding setup phase, the bus is ignored.
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = CNT_LOAD;
        end
      end

      ACCESS: begin
        if (!PSEL) begin
          // The bridge abandoned the transfer. Nothing is written and no
          // error is reported.
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (PENABLE) begin
          // This is the completion edge. Returning straight to IDLE lets a
          // setup phase in the next cycle be accepted.
          state_d = IDLE;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and latched-transfer registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      // NOTE: sequential state is updated only with non-blocking assignments,
      // so every flop samples values from before the edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register-file memory
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      // NOTE: this array is deliberately reset. The block must read back 0
      // from every location after reset, so it is built from flops rather
      // than a RAM macro.
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_idx] <= wdata_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // A read of a location written on the previous completion edge returns the
  // new value, because the array read is asynchronous.
  always_comb begin
    PREADY  = ready;
    PSLVERR = ready && !in_range;
    PRDATA  = '0;
    if (ready && !write_q && in_range) begin
      PRDATA = mem_q[mem_idx];
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
//
// Drives two instances of apb_slave_mem. Instance A uses the default two wait
// states and instance B uses zero wait states. The two instances share the
// bus, and each has its own PSEL.
//
// Every transfer pushes its expected response (read data, error flag, total
// cycle count) into a scoreboard queue. The expected response comes from a
// bench-side memory model. The entry is popped and compared when the DUT
// completes the transfer. Inputs are driven, and outputs sampled, on the
// falling edge of the clock.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       psel_a, psel_b, penable, pwrite;
  logic [7:0] paddr, pwdata;

  logic [7:0] prdata_a, prdata_b;
  logic       pready_a, pready_b, pslverr_a, pslverr_b;

  always #5 clk = ~clk;

  apb_slave_mem dut_a (
    .PCLK    (clk),
    .PRESET  (rst),
    .PSEL    (psel_a),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata_a),
    .PREADY  (pready_a),
    .PSLVERR (pslverr_a)
  );

  apb_slave_mem #(.WAIT_CYCLES(0)) dut_b (
    .PCLK    (clk),
    .PRESET  (rst),
    .PSEL    (psel_b),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata_b),
    .PREADY  (pready_b),
    .PSLVERR (pslverr_b)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cycles;
    bit         is_read;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_a [256];
  logic [7:0] model_b [256];
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit b, output logic rdy, output logic err, output logic [7:0] rd);
    if (b) begin
      rdy = pready_b; err = pslverr_b; rd = prdata_b;
    end else begin
      rdy = pready_a; err = pslverr_a; rd = prdata_a;
    end
  endtask

  task automatic set_sel(input bit b, input logic v);
    if (b) psel_b = v;
    else   psel_a = v;
  endtask

  // This task must be called at a falling edge while the DUT is idle. It
  // returns at the falling edge after the completion edge, so a following
  // call starts its setup phase with no idle gap.
  task automatic xfer(input bit b, input bit wr, input logic [7:0] a,
                      input logic [7:0] d, input string tag);
    exp_t       e, got;
    int         wc, cyc;
    bit         done;
    logic       rdy, err;
    logic [7:0] rd, cap_rd;
    logic       cap_err;

    wc        = b ? 0 : 2;
    e.is_read = !wr;
    e.err     = (a >= 8'h80);
    e.cycles  = wc + 2;
    e.rdata   = (wr || e.err) ? 8'h00 : (b ? model_b[a] : model_a[a]);
    if (wr && !e.err) begin
      if (b) model_b[a] = d;
      else   model_a[a] = d;
    end
    sb.push_back(e);

    sample(b, rdy, err, rd);
    check({tag, "/idle_pready"}, rdy, 1'b0);

    set_sel(b, 1'b1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    cyc     = 1;
    @(negedge clk);
    penable = 1'b1;
    // The DUT must ignore bus changes during the access phase.
    paddr   = ~a;
    pwdata  = ~d;
    pwrite  = !wr;

    done    = 0;
    cap_rd  = 8'hxx;
    cap_err = 1'bx;
    for (int i = 0; i < 16; i++) begin
      sample(b, rdy, err, rd);
      cyc++;
      if (rdy) begin
        done    = 1;
        cap_rd  = rd;
        cap_err = err;
      end else begin
        check({tag, "/wait_pslverr"}, err, 1'b0);
      end
      @(negedge clk);
      if (done) break;
    end
    set_sel(b, 1'b0);
    penable = 1'b0;

    got = sb.pop_front();
    check({tag, "/completed"}, done, 1'b1);
    check({tag, "/cycles"}, cyc, got.cycles);
    check({tag, "/pslverr"}, cap_err, got.err);
    if (got.is_read) check({tag, "/prdata"}, cap_rd, got.rdata);
  endtask

  initial begin
    logic       rdy, err;
    logic [7:0] rd;

    for (int i = 0; i < 256; i++) begin
      model_a[i] = 8'h00;
      model_b[i] = 8'h00;
    end
    rst = 1'b1; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    repeat (2) @(negedge clk);
    check("reset/pready_a",  pready_a,  1'b0);
    check("reset/pslverr_a", pslverr_a, 1'b0);
    check("reset/prdata_a",  prdata_a,  8'h00);
    check("reset/pready_b",  pready_b,  1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Two wait states: write, then read back.
    xfer(0, 1, 8'h10, 8'hA5, "wr10");
    xfer(0, 0, 8'h10, 8'h00, "rd10");

    // Zero wait states on instance B.
    xfer(1, 1, 8'h7F, 8'h3C, "b_wr7f");
    xfer(1, 0, 8'h7F, 8'h00, "b_rd7f");

    // Out-of-range accesses. The neighbouring in-range locations must not
    // change.
    xfer(0, 1, 8'h00, 8'h12, "wr00");
    xfer(0, 1, 8'h7F, 8'h34, "wr7f");
    xfer(0, 1, 8'h80, 8'hFF, "wr80_err");
    xfer(0, 0, 8'h80, 8'h00, "rd80_err");
    xfer(0, 0, 8'h00, 8'h00, "rd00");
    xfer(0, 0, 8'h7F, 8'h00, "rd7f");

    // PSEL drops after the first access cycle, so the transfer is aborted.
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'h55;
    @(negedge clk);
    penable = 1'b1;
    sample(0, rdy, err, rd);
    check("abort/access1_pready", rdy, 1'b0);
    @(negedge clk);
    psel_a = 1'b0; penable = 1'b0;
    sample(0, rdy, err, rd);
    check("abort/access2_pready", rdy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample(0, rdy, err, rd);
      check("abort/idle_pready", rdy, 1'b0);
    end
    xfer(0, 0, 8'h20, 8'h00, "abort_rd20");

    // PSEL and PENABLE high in IDLE without a setup phase are ignored.
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample(0, rdy, err, rd);
      check("noset/pready", rdy, 1'b0);
    end
    psel_a = 1'b0; penable = 1'b0;
    @(negedge clk);

    // Reset asserted during the wait states of a write.
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'h99;
    @(negedge clk);
    penable = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_mid/pready",  pready_a,  1'b0);
    check("rst_mid/pslverr", pslverr_a, 1'b0);
    check("rst_mid/prdata",  prdata_a,  8'h00);
    repeat (3) @(negedge clk);
    check("rst_mid/held_pready", pready_a, 1'b0);
    psel_a = 1'b0; penable = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      model_a[i] = 8'h00;
      model_b[i] = 8'h00;
    end
    @(negedge clk);
    xfer(0, 0, 8'h05, 8'h00, "rst_rd05");
    xfer(0, 0, 8'h10, 8'h00, "rst_rd10");
    xfer(0, 1, 8'h06, 8'h6A, "rst_wr06");
    xfer(0, 0, 8'h06, 8'h00, "rst_rd06");

    // Back-to-back transfers: each setup phase follows the previous
    // completion with no idle cycle.
    xfer(0, 1, 8'h01, 8'h11, "b2b_wr01");
    xfer(0, 0, 8'h01, 8'h00, "b2b_rd01");
    xfer(1, 1, 8'h01, 8'h22, "b2b_b_wr01");
    xfer(1, 0, 8'h01, 8'h00, "b2b_b_rd01");
    xfer(1, 0, 8'h90, 8'h00, "b_rd90_err");

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer (slave) sitting at the far end of the APB bridge's PSEL1/PSEL2 lines.
- One instance is placed per select line.
- Contains a byte-wide register-file memory.
- Inserts a programmable number of wait states via PREADY.
- Flags out-of-range accesses with PSLVERR.
- The bridge routes PADDR[8] to the select lines; this block receives only the low address bits.

Parameters:
- ADDR_W, 8, local address width (PADDR[7:0] from the bridge).
- DATA_W, 8, data width.
- MEM_DEPTH, 128, number of implemented locations; addresses >= MEM_DEPTH are errors.
- WAIT_CYCLES, 2, wait states inserted in every access phase (0 = zero-wait).

Ports:
- PCLK  input  1  clock, rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  slave select from bridge.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_W  local address.
- PWDATA  input  DATA_W  write data.
- PRDATA  output  DATA_W  read data.
- PREADY  output  1  transfer completes on the edge where PREADY=1.
- PSLVERR  output  1  error response; valid only while PREADY=1.

Behaviour:
- Interface: one clock (PCLK); reset PRESET is asynchronous and active-high.
- Reset: state=IDLE, wait counter=0, all memory locations=0, PREADY=0, PSLVERR=0, PRDATA=0. Assertion mid-transfer aborts the transfer immediately; no memory write occurs.
- States: IDLE, ACCESS.
- IDLE:
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - Setup phase (PSEL=1, PENABLE=0) sampled at an edge: latch PADDR, PWRITE, PWDATA; load counter=WAIT_CYCLES; go to ACCESS.
  - PSEL=1 with PENABLE=1 in IDLE (no setup phase seen): ignored, stay IDLE, PREADY stays 0.
- ACCESS:
  - PREADY = (counter==0), combinational from registered state and counter.
  - While counter!=0 and PSEL=1: decrement each edge.
  - Edge with PSEL=1, PENABLE=1, PREADY=1 completes the transfer and returns to IDLE.
  - Write, in range: mem[latched addr] <= latched PWDATA on the completion edge.
  - Write, out of range: memory is not written.
  - Read: PRDATA = mem[latched addr] (asynchronous array read) while PREADY=1; otherwise 0.
  - Error: PSLVERR = PREADY & (latched addr >= MEM_DEPTH). On error, PRDATA=0.
  - PSEL falling to 0 in ACCESS aborts to IDLE on that edge; no write, no error.
- Latency: completion is WAIT_CYCLES+1 cycles after the setup cycle, so the minimum transfer is 2 cycles (setup + access) with WAIT_CYCLES=0.
- Back-to-back: the completion edge returns to IDLE, so a setup phase in the very next cycle is accepted with no idle gap required.
- Latching: PADDR, PWRITE and PWDATA changes during ACCESS are ignored; the latched values are used.
- A read of an address written on the previous completion edge returns the new data.
- Counter width is clog2(WAIT_CYCLES+1), minimum 1 bit.

Test Plan:
- Write 0xA5 to addr 0x10, then read addr 0x10 (WAIT_CYCLES=2): each access phase shows PREADY=0,0,1. The read returns PRDATA=0xA5, PSLVERR=0. A transfer takes 4 cycles including setup.
- WAIT_CYCLES=0 override: write 0x3C to 0x7F then read it back. PREADY=1 in the first access cycle, PRDATA=0x3C, and each transfer takes 2 cycles.
- Write 0xFF to addr 0x80 (>= MEM_DEPTH): PSLVERR=1 with PREADY=1. A subsequent read of 0x80 gives PSLVERR=1, PRDATA=0. Reads of 0x00 and 0x7F are unchanged.
- Write 0x55 to 0x20, then drop PSEL after the first access cycle: block returns to IDLE with PREADY never 1. A read of 0x20 returns 0x00.
- Assert PRESET during the wait states of a write of 0x99 to 0x05: outputs go to 0 immediately. After release, a read of 0x05 returns 0x00 and a new transfer works normally.
- Back-to-back write 0x11 to 0x01, then read 0x01 with setup in the cycle right after PREADY: the read is accepted and returns 0x11.
